// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-side memory responder:
// FSM states, request bundle and the latency ceiling.
package rv32i_types;

  localparam int DMEM_MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/dmem_responder_sram_array.sv
// Single-port word array with byte enables:
// combinational read of the addressed word, write on the clock edge.
module dmem_sram_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [3:0]            be,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [2**DEPTH_LOG2];

  // Contents survive reset on purpose, so there is no reset term.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i+:8] <= wdata[8*i+:8];
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the dmem request interface: accepts one masked request,
// waits LATENCY cycles, then pulses a one-cycle response.
module dmem_responder
  import rv32i_types::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        proto_err
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  dmem_req_t   req;
  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        req_vld, is_wr, accept;
  logic [31:0] arr_rdata;

  assign req     = '{addr: dmem_addr, rmask: dmem_rmask,
                     wmask: dmem_wmask, wdata: dmem_wdata};
  assign req_vld = (|req.rmask) | (|req.wmask);
  assign is_wr   = |req.wmask;

  dmem_sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (accept & is_wr),
    .idx  (req.addr[DEPTH_LOG2+1:2]),
    .be   (req.wmask),
    .wdata(req.wdata),
    .rdata(arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        if (req_vld) accept = 1'b1;
        else         state_d = IDLE;
      end
      WAIT: begin
        if (req_vld) err_d = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      cnt_d   = LAT_M1;
      state_d = (LATENCY == 1) ? RESP : WAIT;
      // A dual-mask request is a write; its read half is dropped.
      rdata_d = is_wr ? 32'd0 : (arr_rdata & lane_mask(req.rmask));
      if (is_wr && (|req.rmask)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign dmem_resp  = (state_q == RESP);
  assign dmem_rdata = dmem_resp ? rdata_q : 32'd0;
  assign proto_err  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=1 instances
// checked against a word-array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr  [2];
  logic [3:0]  rm    [2];
  logic [3:0]  wm    [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        resp  [2];
  logic        perr  [2];

  int ncmp = 0;
  int nerr = 0;

  logic [31:0] mm [2][1024];
  logic        err_m [2];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst),
    .dmem_addr(addr[0]), .dmem_rmask(rm[0]), .dmem_wmask(wm[0]),
    .dmem_wdata(wdata[0]), .dmem_rdata(rdata[0]),
    .dmem_resp(resp[0]), .proto_err(perr[0])
  );

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .dmem_addr(addr[1]), .dmem_rmask(rm[1]), .dmem_wmask(wm[1]),
    .dmem_wdata(wdata[1]), .dmem_rdata(rdata[1]),
    .dmem_resp(resp[1]), .proto_err(perr[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] lm(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = {8{m[i]}};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic [31:0] a,
                       input logic [3:0] r, input logic [3:0] w,
                       input logic [31:0] d);
    addr[k] = a; rm[k] = r; wm[k] = w; wdata[k] = d;
  endtask

  task automatic txn(input int k, input logic [31:0] a,
                     input logic [3:0] r, input logic [3:0] w,
                     input logic [31:0] d);
    logic [31:0] exp;
    int idx;
    idx = int'(a[11:2]);
    if (w != 4'd0) begin
      for (int i = 0; i < 4; i++)
        if (w[i]) mm[k][idx][8*i+:8] = d[8*i+:8];
      exp = 32'd0;
      if (r != 4'd0) err_m[k] = 1'b1;
    end else begin
      exp = mm[k][idx] & lm(r);
    end
    drive(k, a, r, w, d);
    step();
    drive(k, 32'd0, 4'd0, 4'd0, 32'd0);
    for (int c = 1; c < lat_of(k); c++) begin
      chk("wait_resp", 32'(resp[k]), 32'd0);
      chk("wait_rdata", rdata[k], 32'd0);
      step();
    end
    chk("resp", 32'(resp[k]), 32'd1);
    chk("rdata", rdata[k], exp);
    chk("proto_err", 32'(perr[k]), 32'(err_m[k]));
  endtask

  task automatic reset_pulse();
    #2;
    rst = 1'b1;
    err_m[0] = 1'b0;
    err_m[1] = 1'b0;
    #1;
    chk("rst_resp", 32'(resp[0]), 32'd0);
    chk("rst_rdata", rdata[0], 32'd0);
    chk("rst_perr", 32'(perr[0]), 32'd0);
    drive(0, 32'd0, 4'd0, 4'd0, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("post_rst_resp", 32'(resp[0]), 32'd0);
      step();
    end
  endtask

  initial begin
    logic [9:0]  widx [8];
    logic [31:0] a;
    logic [3:0]  r, w;
    int          kind, k;

    widx = '{10'd0, 10'd1, 10'd5, 10'd64, 10'd65, 10'd200, 10'd511, 10'd1023};
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 1024; i++) mm[j][i] = 32'd0;
      err_m[j] = 1'b0;
      drive(j, 32'd0, 4'd0, 4'd0, 32'd0);
    end

    repeat (2) step();
    for (int j = 0; j < 2; j++) begin
      chk("reset_resp", 32'(resp[j]), 32'd0);
      chk("reset_rdata", rdata[j], 32'd0);
      chk("reset_perr", 32'(perr[j]), 32'd0);
    end
    rst = 1'b0;
    step();

    txn(0, 32'h100, 4'h0, 4'hF, 32'hDEADBEEF);
    txn(0, 32'h100, 4'hF, 4'h0, 32'd0);
    step();
    chk("idle_after_resp", 32'(resp[0]), 32'd0);

    txn(0, 32'h100, 4'h0, 4'hF, 32'h11223344);
    txn(0, 32'h103, 4'h0, 4'h8, 32'hAA000000);
    txn(0, 32'h100, 4'hF, 4'h0, 32'd0);
    txn(0, 32'h100, 4'h4, 4'h0, 32'd0);
    step();

    txn(0, 32'h1000, 4'h0, 4'hF, 32'hCAFEF00D);
    txn(0, 32'h0, 4'hF, 4'h0, 32'd0);
    step();

    for (int i = 0; i < 4; i++)
      txn(1, 32'h40 * i, 4'h0, 4'hF, 32'h5000_0000 + i);
    for (int i = 0; i < 4; i++)
      txn(1, 32'h40 * i, 4'hF, 4'h0, 32'd0);
    step();
    chk("l1_idle", 32'(resp[1]), 32'd0);

    txn(0, 32'h200, 4'h0, 4'hF, 32'h13579BDF);
    txn(0, 32'h204, 4'h0, 4'hF, 32'hA5A5A5A5);
    step();
    drive(0, 32'h200, 4'hF, 4'h0, 32'd0);
    step();
    drive(0, 32'h200, 4'h0, 4'hF, 32'hFFFFFFFF);
    err_m[0] = 1'b1;
    step();
    drive(0, 32'd0, 4'd0, 4'd0, 32'd0);
    chk("wait_req_resp", 32'(resp[0]), 32'd1);
    chk("wait_req_rdata", rdata[0], 32'h13579BDF);
    chk("wait_req_perr", 32'(perr[0]), 32'd1);
    step();
    chk("wait_req_idle", 32'(resp[0]), 32'd0);
    txn(0, 32'h204, 4'h1, 4'h1, 32'h00000055);
    txn(0, 32'h204, 4'hF, 4'h0, 32'd0);
    txn(0, 32'h200, 4'hF, 4'h0, 32'd0);
    step();
    chk("perr_sticky", 32'(perr[0]), 32'd1);

    drive(0, 32'h100, 4'hF, 4'h0, 32'd0);
    step();
    reset_pulse();
    txn(0, 32'h100, 4'hF, 4'h0, 32'd0);
    reset_pulse();
    txn(0, 32'h100, 4'hF, 4'h0, 32'd0);
    step();

    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 8; i++)
        txn(j, {20'd0, widx[i], 2'd0}, 4'h0, 4'hF, $urandom);
      step();
    end
    for (int n = 0; n < 80; n++) begin
      k    = (n % 5 == 4) ? 1 : 0;
      a    = ($urandom & 32'hFFFF_F003) |
             {20'd0, widx[$urandom_range(0, 7)], 2'd0};
      kind = int'($urandom_range(0, 9));
      r    = 4'($urandom_range(1, 15));
      w    = 4'($urandom_range(1, 15));
      if (kind < 5)      w = 4'd0;
      else if (kind < 9) r = 4'd0;
      txn(k, a, r, w, $urandom);
      if ($urandom_range(0, 1) == 1) step();
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
